// File: rtl/hazard_pkg.sv
// Shared opcode constants and hazard-sequencer state encoding for the
// 5-stage RV64 pipeline control logic.
package hazard_pkg;

  localparam logic [6:0] MATHr  = 7'b0110011;
  localparam logic [6:0] MATHWr = 7'b0111011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_FETCH_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/reg_use_decode.sv
// Extracts source-register fields from an instruction and flags which of
// them the opcode actually reads; shared with the forwarding unit.
module reg_use_decode
  import hazard_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0] opcode;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  // Immediate, funct and rd fields play no part in operand usage.
  assign unused_inst_bits = ^{inst[31:25], inst[14:7]};

  assign rs1_used = (opcode != JAL) && (opcode != LUI) && (opcode != AUIPC);
  assign rs2_used = (opcode == MATHr) || (opcode == MATHWr) ||
                    (opcode == BRANCH) || (opcode == STORE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer covering load-use, redirect, fetch-wait and
// data-memory-wait hazards, with performance counters and a timeout flag.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_t          state_q, state_d;
  logic [4:0]      rs1, rs2;
  logic            rs1_used, rs2_used;
  logic            load_use;
  logic            mem_wait;
  logic            redirect;
  logic [TO_W-1:0] to_cnt, to_cnt_d;

  reg_use_decode u_decode (
    .inst     (id_inst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    mem_wait     = 1'b0;
    redirect     = 1'b0;
    state_d      = ST_RUN;
    // Outputs are forced quiet while reset is held, regardless of inputs.
    if (!rst) begin
      if (dmem_req && !dmem_ready) begin
        // EX is frozen, so branch and load-use are re-evaluated next cycle.
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
        mem_wait     = 1'b1;
        state_d      = ST_MEM_WAIT;
      end else if (ex_branch_taken) begin
        // The squashed ID instruction cannot cause a load-use stall.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        redirect   = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        state_d    = ST_FETCH_WAIT;
      end
    end
  end

  always_comb begin
    to_cnt_d = '0;
    if (mem_wait) begin
      to_cnt_d = (to_cnt == TO_LIMIT) ? to_cnt : to_cnt + TO_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values; combinational blocks above use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt       <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      to_cnt <= to_cnt_d;
      if (to_cnt_d == TO_LIMIT) begin
        mem_timeout <= 1'b1;
      end
      if (pc_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (redirect && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (TIMEOUT = 4 and
// 4-bit counters so timeout and saturation are reachable quickly).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;
  localparam int CNT_MAX = 15;

  // Control vector order: pc, ifid_stall, ifid_flush, idex_stall,
  // idex_flush, exmem_stall, memwb_bubble.
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_MW   = 7'b1101011;
  localparam logic [6:0] C_FW   = 7'b1010000;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_FW  = 2'd2;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      id_inst;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic             exmem_stall, memwb_bubble;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [6:0]       ctl;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  int exp_to = 0;
  logic exp_timeout = 1'b0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_inst         (id_inst),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_stall      (idex_stall),
    .idex_flush      (idex_flush),
    .exmem_stall     (exmem_stall),
    .memwb_bubble    (memwb_bubble),
    .state           (state),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, memwb_bubble};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic check_regs(input string tag, input logic [1:0] exp_st);
    check({tag, ":state"}, 32'(state), 32'(exp_st));
    check({tag, ":stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    check({tag, ":flush_count"}, 32'(flush_count), 32'(exp_flush));
    check({tag, ":mem_timeout"}, 32'(mem_timeout), 32'(exp_timeout));
  endtask

  // Drives one cycle of inputs just after a rising edge, checks the
  // combinational controls, clocks, then checks the registered state.
  task automatic vec(input string tag, input logic [31:0] inst, input logic mr,
                     input logic [4:0] rd, input logic br, input logic im,
                     input logic dq, input logic dr,
                     input logic [6:0] exp_ctl, input logic [1:0] exp_st);
    id_inst = inst; ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
    imem_ready = im; dmem_req = dq; dmem_ready = dr;
    #1;
    check({tag, ":ctl"}, 32'(ctl), 32'(exp_ctl));
    @(posedge clk);
    #1;
    if (exp_ctl[6] && exp_stall != CNT_MAX) exp_stall++;
    if (exp_ctl == C_BR && exp_flush != CNT_MAX) exp_flush++;
    if (exp_ctl == C_MW) begin
      if (exp_to != TIMEOUT) exp_to++;
    end else begin
      exp_to = 0;
    end
    if (exp_to == TIMEOUT) exp_timeout = 1'b1;
    check_regs(tag, exp_st);
  endtask

  logic [31:0] add_x6_x5_x1, sd_x5_x2, lui_x5, add_x0, jal_x5, auipc_x5;
  logic [31:0] addi_rs2f5, beq_x1_x5, ld_x7_x5, idle;

  initial begin
    add_x6_x5_x1 = mk(7'b0110011, 5'd5, 5'd1, 5'd6);
    sd_x5_x2     = mk(7'b0100011, 5'd2, 5'd5, 5'd0);
    lui_x5       = mk(7'b0110111, 5'd5, 5'd5, 5'd5);
    add_x0       = mk(7'b0110011, 5'd0, 5'd0, 5'd6);
    jal_x5       = mk(7'b1101111, 5'd5, 5'd5, 5'd1);
    auipc_x5     = mk(7'b0010111, 5'd5, 5'd5, 5'd3);
    addi_rs2f5   = mk(7'b0010011, 5'd2, 5'd5, 5'd8);
    beq_x1_x5    = mk(7'b1100011, 5'd1, 5'd5, 5'd0);
    ld_x7_x5     = mk(7'b0000011, 5'd5, 5'd0, 5'd7);
    idle         = 32'h0000_0013;

    // Reset with every hazard input active: controls must stay quiet.
    rst = 1'b1;
    id_inst = add_x6_x5_x1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    ex_branch_taken = 1'b1; imem_ready = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
    #2;
    check("reset:ctl", 32'(ctl), 32'(C_NONE));
    repeat (2) @(posedge clk);
    #1;
    check("reset:ctl_held", 32'(ctl), 32'(C_NONE));
    check_regs("reset", S_RUN);
    rst = 1'b0;

    vec("idle", idle, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);

    // Load-use decode cases.
    vec("lu_add",   add_x6_x5_x1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_LU,   S_RUN);
    check("lu_add:one_stall", 32'(stall_cycles), 32'd1);
    vec("lu_after", add_x6_x5_x1, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);
    vec("lu_sd",    sd_x5_x2,     1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_LU,   S_RUN);
    vec("lu_lui",   lui_x5,       1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);
    vec("lu_x0",    add_x0,       1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);
    vec("lu_jal",   jal_x5,       1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);
    vec("lu_auipc", auipc_x5,     1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);
    vec("lu_addi",  addi_rs2f5,   1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);
    vec("lu_beq",   beq_x1_x5,    1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_LU,   S_RUN);
    vec("lu_ld",    ld_x7_x5,     1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_LU,   S_RUN);
    vec("lu_noload", add_x6_x5_x1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);

    // Branch together with load-use: flush wins.
    vec("br_lu", add_x6_x5_x1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, S_RUN);
    check("br_lu:flush1", 32'(flush_count), 32'd1);

    // Memory wait masks a pending branch for 3 cycles, then the flush issues.
    for (int i = 0; i < 3; i++)
      vec("mw_br", idle, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, C_MW, S_MW);
    vec("mw_release", idle, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, C_BR, S_RUN);
    check("mw_release:no_timeout", 32'(mem_timeout), 32'd0);

    // Timeout after 4 consecutive wait cycles, sticky afterwards.
    for (int i = 0; i < 6; i++)
      vec("to_wait", idle, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_MW, S_MW);
    check("to_wait:flag", 32'(mem_timeout), 32'd1);
    vec("to_release", idle, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_NONE, S_RUN);
    vec("to_sticky",  idle, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);

    // Reset asserted mid-wait clears everything asynchronously.
    vec("rst_wait", idle, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_MW, S_MW);
    rst = 1'b1;
    #1;
    exp_stall = 0; exp_flush = 0; exp_to = 0; exp_timeout = 1'b0;
    check("rst_mid:ctl", 32'(ctl), 32'(C_NONE));
    check_regs("rst_mid", S_RUN);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch wait, then return to RUN.
    vec("fw0", idle, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FW, S_FW);
    vec("fw1", idle, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FW, S_FW);
    vec("fw_done", idle, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE, S_RUN);
    check("fw_done:stall2", 32'(stall_cycles), 32'd2);
    vec("fw_br", idle, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_BR, S_RUN);
    vec("fw_lu", add_x6_x5_x1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, S_RUN);

    // Counter saturation.
    for (int i = 0; i < 16; i++)
      vec("sat_stall", idle, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FW, S_FW);
    check("sat_stall:max", 32'(stall_cycles), 32'd15);
    for (int i = 0; i < 16; i++)
      vec("sat_flush", idle, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, S_RUN);
    check("sat_flush:max", 32'(flush_count), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
